// File: rtl/rename_stage_pkg.sv
// ---------------------------------------------------------------------------
// rename_stage_pkg
// Shared widths, types and opcode encodings for the rename stage and the
// surrounding pipeline. No ports; imported by every rename file.
// ---------------------------------------------------------------------------
package rename_stage_pkg;

  localparam int XLEN      = 32;
  localparam int PREG_W    = 7;
  localparam int AREG_W    = 5;
  localparam int ROB_W     = 3;
  localparam int LSQ_W     = 2;
  localparam int NUM_PREG  = 128;
  localparam int NUM_AREG  = 32;
  localparam int ROB_DEPTH = 8;
  localparam int FL_PTR_W  = PREG_W + 1;
  // Architectural registers start out mapped to p0..p31, so the rest are free.
  localparam int INIT_FREE = NUM_PREG - NUM_AREG;

  typedef logic [PREG_W-1:0]   preg_t;
  typedef logic [AREG_W-1:0]   areg_t;
  typedef logic [ROB_W-1:0]    rob_idx_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

  typedef enum logic [4:0] {
    R_TYPE = 5'd0,
    I_TYPE = 5'd1,
    LOAD   = 5'd2,
    STORE  = 5'd3,
    B_TYPE = 5'd4,
    JAL    = 5'd5,
    JALR   = 5'd6,
    LUI    = 5'd7,
    AUIPC  = 5'd8
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  inst;
    logic [XLEN-1:0]  imm;
    logic [4:0]       op;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [2:0]       fu_sel;
    logic             jump;
    preg_t            rs1;
    preg_t            rs2;
    preg_t            rd;
    preg_t            old_rd;
    logic             rs1_valid;
    logic             rs2_valid;
    rob_idx_t         rob_idx;
    logic [LSQ_W-1:0] lq_tail;
    logic [LSQ_W-1:0] sq_tail;
  } is_entry_t;

  // Instructions that may redirect fetch need a recovery point.
  function automatic logic needs_snapshot(logic [4:0] op, logic jump);
    return jump || (op == B_TYPE);
  endfunction

endpackage

// File: rtl/rename_if.sv
// ---------------------------------------------------------------------------
// rename_if
// Bundle of every rename-stage signal except clock and reset.
//   master : decode / ROB / LSQ / issue / writeback / commit side
//   slave  : the rename stage itself
// ---------------------------------------------------------------------------
interface rename_if;
  import rename_stage_pkg::*;

  // decode -> rename
  logic             DC_in_valid;
  logic             DC_in_ready;
  logic [XLEN-1:0]  DC_in_pc;
  logic [XLEN-1:0]  DC_in_inst;
  logic [XLEN-1:0]  DC_in_imm;
  logic [4:0]       DC_in_op;
  logic [2:0]       DC_in_f3;
  logic [6:0]       DC_in_f7;
  logic [2:0]       DC_in_fu_sel;
  logic             DC_in_jump;
  areg_t            DC_in_rs1;
  areg_t            DC_in_rs2;
  areg_t            DC_in_rd;
  logic             DC_in_rd_we;

  // ROB / load-store queue status
  rob_idx_t         ROB_tail;
  logic             ROB_ready;
  logic [LSQ_W-1:0] LQ_tail;
  logic [LSQ_W-1:0] SQ_tail;

  // rename -> issue queue
  logic             DC_valid;
  logic             IS_ready;
  logic [XLEN-1:0]  IS_in_pc;
  logic [XLEN-1:0]  IS_in_inst;
  logic [XLEN-1:0]  IS_in_imm;
  logic [4:0]       IS_in_op;
  logic [2:0]       IS_in_f3;
  logic [6:0]       IS_in_f7;
  logic [2:0]       IS_in_fu_sel;
  logic             IS_in_jump;
  preg_t            IS_in_rs1;
  preg_t            IS_in_rs2;
  preg_t            IS_in_rd;
  preg_t            IS_in_old_rd;
  logic             IS_in_rs1_valid;
  logic             IS_in_rs2_valid;
  rob_idx_t         IS_in_rob_idx;
  logic [LSQ_W-1:0] IS_in_LQ_tail;
  logic [LSQ_W-1:0] IS_in_SQ_tail;

  // writeback, commit, recovery
  logic             WB_valid;
  preg_t            WB_rd;
  logic             commit_valid;
  preg_t            commit_old_rd;
  logic             mispredict;
  rob_idx_t         mispredict_rob_idx;
  logic [ROB_DEPTH-1:0] flush_mask;

  modport master (
    output DC_in_valid, DC_in_pc, DC_in_inst, DC_in_imm, DC_in_op, DC_in_f3,
           DC_in_f7, DC_in_fu_sel, DC_in_jump, DC_in_rs1, DC_in_rs2, DC_in_rd,
           DC_in_rd_we, ROB_tail, ROB_ready, LQ_tail, SQ_tail, IS_ready,
           WB_valid, WB_rd, commit_valid, commit_old_rd, mispredict,
           mispredict_rob_idx, flush_mask,
    input  DC_in_ready, DC_valid, IS_in_pc, IS_in_inst, IS_in_imm, IS_in_op,
           IS_in_f3, IS_in_f7, IS_in_fu_sel, IS_in_jump, IS_in_rs1, IS_in_rs2,
           IS_in_rd, IS_in_old_rd, IS_in_rs1_valid, IS_in_rs2_valid,
           IS_in_rob_idx, IS_in_LQ_tail, IS_in_SQ_tail
  );

  modport slave (
    input  DC_in_valid, DC_in_pc, DC_in_inst, DC_in_imm, DC_in_op, DC_in_f3,
           DC_in_f7, DC_in_fu_sel, DC_in_jump, DC_in_rs1, DC_in_rs2, DC_in_rd,
           DC_in_rd_we, ROB_tail, ROB_ready, LQ_tail, SQ_tail, IS_ready,
           WB_valid, WB_rd, commit_valid, commit_old_rd, mispredict,
           mispredict_rob_idx, flush_mask,
    output DC_in_ready, DC_valid, IS_in_pc, IS_in_inst, IS_in_imm, IS_in_op,
           IS_in_f3, IS_in_f7, IS_in_fu_sel, IS_in_jump, IS_in_rs1, IS_in_rs2,
           IS_in_rd, IS_in_old_rd, IS_in_rs1_valid, IS_in_rs2_valid,
           IS_in_rob_idx, IS_in_LQ_tail, IS_in_SQ_tail
  );

endinterface

// File: rtl/rn_free_list.sv
// ---------------------------------------------------------------------------
// rn_free_list
// Circular list of free physical tags with per-ROB-entry head snapshots.
//   clk, rst          : clock, async active-low reset
//   pop               : consume head_tag this cycle
//   push, push_tag    : return a tag at the tail
//   snap_we, snap_idx : record the post-pop head for ROB entry snap_idx
//   restore, restore_idx : rewind head to a recorded snapshot
//   head_tag          : tag that the next pop will return
//   count             : number of free tags (tail - head)
// ---------------------------------------------------------------------------
module rn_free_list
  import rename_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     pop,
  input  logic     push,
  input  preg_t    push_tag,
  input  logic     snap_we,
  input  rob_idx_t snap_idx,
  input  logic     restore,
  input  rob_idx_t restore_idx,
  output preg_t    head_tag,
  output fl_ptr_t  count
);

  preg_t   slots     [NUM_PREG];
  fl_ptr_t snap_head [ROB_DEPTH];
  fl_ptr_t head;
  fl_ptr_t tail;
  fl_ptr_t head_popped;

  // Pointers carry one extra wrap bit so a full and an empty list differ.
  assign head_popped = head + fl_ptr_t'(pop);
  assign head_tag    = slots[head[PREG_W-1:0]];
  assign count       = tail - head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PREG; i++) begin
        slots[i] <= (i < INIT_FREE) ? preg_t'(i + NUM_AREG) : '0;
      end
      for (int i = 0; i < ROB_DEPTH; i++) begin
        snap_head[i] <= '0;
      end
      head <= '0;
      tail <= fl_ptr_t'(INIT_FREE);
    end else begin
      // Restore never coincides with a pop: no instruction is accepted then.
      if (restore) begin
        head <= snap_head[restore_idx];
      end else begin
        head <= head_popped;
      end
      if (push) begin
        slots[tail[PREG_W-1:0]] <= push_tag;
        tail                    <= tail + fl_ptr_t'(1);
      end
      if (snap_we) begin
        snap_head[snap_idx] <= head_popped;
      end
    end
  end

endmodule

// File: rtl/rename_stage.sv
// ---------------------------------------------------------------------------
// rename_stage
// Maps architectural registers to physical tags, tracks tag readiness, and
// hands one renamed instruction per cycle to the issue queue through a
// registered valid/ready stage. Branch/jump snapshots allow single-cycle
// recovery on mispredict.
//   clk : clock (rising edge)
//   rst : async active-low reset
//   bus : rename_if.slave -- decode input, ROB/LSQ status, issue output,
//         writeback, commit and mispredict signals
// ---------------------------------------------------------------------------
module rename_stage
  import rename_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  rename_if.slave  bus
);

  preg_t               rat      [NUM_AREG];
  preg_t               rat_snap [ROB_DEPTH][NUM_AREG];
  logic [NUM_PREG-1:0] busy;

  is_entry_t out_q;
  logic      out_valid;

  preg_t   fl_head_tag;
  fl_ptr_t fl_count;

  logic  accept;
  logic  alloc;
  logic  take_snap;
  logic  wb_clear;
  logic  commit_push;
  preg_t prs1;
  preg_t prs2;
  preg_t prd;
  preg_t old_rd;
  logic  rs1_valid;
  logic  rs2_valid;

  assign bus.DC_in_ready = rst && !bus.mispredict && bus.ROB_ready &&
                           (!out_valid || bus.IS_ready) &&
                           (fl_count != '0 || !bus.DC_in_rd_we || bus.DC_in_rd == '0);

  assign accept      = bus.DC_in_valid && bus.DC_in_ready;
  assign alloc       = accept && bus.DC_in_rd_we && (bus.DC_in_rd != '0);
  assign take_snap   = accept && needs_snapshot(bus.DC_in_op, bus.DC_in_jump);
  assign wb_clear    = bus.WB_valid && (bus.WB_rd != '0);
  assign commit_push = bus.commit_valid && (bus.commit_old_rd != '0);

  assign prs1   = (bus.DC_in_rs1 == '0) ? '0 : rat[bus.DC_in_rs1];
  assign prs2   = (bus.DC_in_rs2 == '0) ? '0 : rat[bus.DC_in_rs2];
  assign prd    = alloc ? fl_head_tag : '0;
  assign old_rd = alloc ? rat[bus.DC_in_rd] : '0;

  // A tag being written back this very cycle is already ready.
  assign rs1_valid = (prs1 == '0) || !busy[prs1] || (bus.WB_valid && bus.WB_rd == prs1);
  assign rs2_valid = (prs2 == '0) || !busy[prs2] || (bus.WB_valid && bus.WB_rd == prs2);

  rn_free_list u_free_list (
    .clk         (clk),
    .rst         (rst),
    .pop         (alloc),
    .push        (commit_push),
    .push_tag    (bus.commit_old_rd),
    .snap_we     (take_snap),
    .snap_idx    (bus.ROB_tail),
    .restore     (bus.mispredict),
    .restore_idx (bus.mispredict_rob_idx),
    .head_tag    (fl_head_tag),
    .count       (fl_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        rat[i] <= preg_t'(i);
      end
      for (int s = 0; s < ROB_DEPTH; s++) begin
        for (int i = 0; i < NUM_AREG; i++) begin
          rat_snap[s][i] <= '0;
        end
      end
      busy <= '0;
    end else begin
      if (bus.mispredict) begin
        for (int i = 0; i < NUM_AREG; i++) begin
          rat[i] <= rat_snap[bus.mispredict_rob_idx][i];
        end
      end else if (alloc) begin
        rat[bus.DC_in_rd] <= prd;
      end
      // Snapshot holds the map as it stands after this instruction's rename.
      if (take_snap) begin
        for (int i = 0; i < NUM_AREG; i++) begin
          rat_snap[bus.ROB_tail][i] <= (alloc && bus.DC_in_rd == areg_t'(i)) ? prd : rat[i];
        end
      end
      // Allocation is applied after the clear so a recycled tag stays busy.
      if (wb_clear) begin
        busy[bus.WB_rd] <= 1'b0;
      end
      if (alloc) begin
        busy[prd] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (accept) begin
      out_valid        <= 1'b1;
      out_q.pc         <= bus.DC_in_pc;
      out_q.inst       <= bus.DC_in_inst;
      out_q.imm        <= bus.DC_in_imm;
      out_q.op         <= bus.DC_in_op;
      out_q.f3         <= bus.DC_in_f3;
      out_q.f7         <= bus.DC_in_f7;
      out_q.fu_sel     <= bus.DC_in_fu_sel;
      out_q.jump       <= bus.DC_in_jump;
      out_q.rs1        <= prs1;
      out_q.rs2        <= prs2;
      out_q.rd         <= prd;
      out_q.old_rd     <= old_rd;
      out_q.rs1_valid  <= rs1_valid;
      out_q.rs2_valid  <= rs2_valid;
      out_q.rob_idx    <= bus.ROB_tail;
      out_q.lq_tail    <= bus.LQ_tail;
      out_q.sq_tail    <= bus.SQ_tail;
    end else if (bus.mispredict && bus.flush_mask[out_q.rob_idx]) begin
      out_valid <= 1'b0;
    end else if (bus.IS_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.DC_valid        = out_valid;
  assign bus.IS_in_pc        = out_q.pc;
  assign bus.IS_in_inst      = out_q.inst;
  assign bus.IS_in_imm       = out_q.imm;
  assign bus.IS_in_op        = out_q.op;
  assign bus.IS_in_f3        = out_q.f3;
  assign bus.IS_in_f7        = out_q.f7;
  assign bus.IS_in_fu_sel    = out_q.fu_sel;
  assign bus.IS_in_jump      = out_q.jump;
  assign bus.IS_in_rs1       = out_q.rs1;
  assign bus.IS_in_rs2       = out_q.rs2;
  assign bus.IS_in_rd        = out_q.rd;
  assign bus.IS_in_old_rd    = out_q.old_rd;
  assign bus.IS_in_rs1_valid = out_q.rs1_valid;
  assign bus.IS_in_rs2_valid = out_q.rs2_valid;
  assign bus.IS_in_rob_idx   = out_q.rob_idx;
  assign bus.IS_in_LQ_tail   = out_q.lq_tail;
  assign bus.IS_in_SQ_tail   = out_q.sq_tail;

endmodule

// File: tb/tb_rename_stage.sv
// ---------------------------------------------------------------------------
// tb_rename_stage
// Directed scenarios plus a randomized stretch, each cycle compared against a
// reference model built from plain arrays and queues (RAT as int array, free
// list as a queue of tags, recovery as re-inserting tags popped since the
// snapshot).
// ---------------------------------------------------------------------------
module tb_rename_stage;
  import rename_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rename_if bus ();

  rename_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model
  int rat_m    [32];
  bit busy_m   [128];
  int free_q   [$];
  int popped   [$];
  int snap_rat [8][32];
  int snap_pops[8];
  int pend_old [$];

  bit          e_valid, e_v1, e_v2, e_jump;
  int          e_rs1, e_rs2, e_rd, e_old, e_rob, e_lq, e_sq, e_op, e_f3, e_f7, e_fu;
  logic [31:0] e_pc, e_inst, e_imm;
  logic        obs_ready;
  logic [31:0] saved_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) rat_m[i] = i;
    for (int i = 0; i < 128; i++) busy_m[i] = 1'b0;
    free_q.delete();
    for (int t = 32; t < 128; t++) free_q.push_back(t);
    popped.delete();
    pend_old.delete();
    for (int s = 0; s < 8; s++) begin
      snap_pops[s] = 0;
      for (int i = 0; i < 32; i++) snap_rat[s][i] = 0;
    end
    e_valid = 0; e_v1 = 0; e_v2 = 0; e_jump = 0;
    e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_old = 0; e_rob = 0; e_lq = 0; e_sq = 0;
    e_op = 0; e_f3 = 0; e_f7 = 0; e_fu = 0;
    e_pc = '0; e_inst = '0; e_imm = '0;
  endfunction

  task automatic check_outputs();
    check("dc_valid",  32'(bus.DC_valid),        32'(e_valid));
    check("pc",        bus.IS_in_pc,             e_pc);
    check("inst",      bus.IS_in_inst,           e_inst);
    check("imm",       bus.IS_in_imm,            e_imm);
    check("op",        32'(bus.IS_in_op),        e_op);
    check("f3",        32'(bus.IS_in_f3),        e_f3);
    check("f7",        32'(bus.IS_in_f7),        e_f7);
    check("fu_sel",    32'(bus.IS_in_fu_sel),    e_fu);
    check("jump",      32'(bus.IS_in_jump),      32'(e_jump));
    check("prs1",      32'(bus.IS_in_rs1),       e_rs1);
    check("prs2",      32'(bus.IS_in_rs2),       e_rs2);
    check("prd",       32'(bus.IS_in_rd),        e_rd);
    check("old_rd",    32'(bus.IS_in_old_rd),    e_old);
    check("rs1_valid", 32'(bus.IS_in_rs1_valid), 32'(e_v1));
    check("rs2_valid", 32'(bus.IS_in_rs2_valid), 32'(e_v2));
    check("rob_idx",   32'(bus.IS_in_rob_idx),   e_rob);
    check("lq_tail",   32'(bus.IS_in_LQ_tail),   e_lq);
    check("sq_tail",   32'(bus.IS_in_SQ_tail),   e_sq);
  endtask

  // One clock: predict ready, advance the model, then compare registered outputs.
  task automatic cycle();
    bit exp_ready, acc, alloc;
    int r1, r2, rd, p1, p2, prd, old, rob, wbt, n;
    #1;
    obs_ready = bus.DC_in_ready;
    r1  = int'(bus.DC_in_rs1);
    r2  = int'(bus.DC_in_rs2);
    rd  = int'(bus.DC_in_rd);
    rob = int'(bus.ROB_tail);
    wbt = bus.WB_valid ? int'(bus.WB_rd) : -1;
    if (!rst) exp_ready = 1'b0;
    else exp_ready = !bus.mispredict && bus.ROB_ready && (!e_valid || bus.IS_ready) &&
                     (free_q.size() != 0 || !bus.DC_in_rd_we || rd == 0);
    check("dc_in_ready", 32'(obs_ready), 32'(exp_ready));
    if (!rst) begin
      model_reset();
    end else begin
      acc   = exp_ready && bus.DC_in_valid;
      alloc = acc && bus.DC_in_rd_we && rd != 0;
      prd = 0; old = 0;
      if (acc) begin
        p1 = (r1 == 0) ? 0 : rat_m[r1];
        p2 = (r2 == 0) ? 0 : rat_m[r2];
        if (alloc) begin
          prd = free_q.pop_front();
          popped.push_back(prd);
          old = rat_m[rd];
        end
        e_valid = 1;
        e_rs1 = p1; e_rs2 = p2; e_rd = prd; e_old = old;
        e_v1 = (p1 == 0) || !busy_m[p1] || (wbt == p1);
        e_v2 = (p2 == 0) || !busy_m[p2] || (wbt == p2);
        e_rob = rob;
        e_lq = int'(bus.LQ_tail); e_sq = int'(bus.SQ_tail);
        e_pc = bus.DC_in_pc; e_inst = bus.DC_in_inst; e_imm = bus.DC_in_imm;
        e_op = int'(bus.DC_in_op); e_f3 = int'(bus.DC_in_f3);
        e_f7 = int'(bus.DC_in_f7); e_fu = int'(bus.DC_in_fu_sel);
        e_jump = bus.DC_in_jump;
      end else if (bus.mispredict && bus.flush_mask[e_rob]) begin
        e_valid = 0;
      end else if (bus.IS_ready) begin
        e_valid = 0;
      end
      if (wbt > 0) busy_m[wbt] = 1'b0;
      if (alloc) begin
        busy_m[prd] = 1'b1;
        rat_m[rd]   = prd;
        if (old != 0) pend_old.push_back(old);
      end
      if (acc && (bus.DC_in_jump || int'(bus.DC_in_op) == int'(B_TYPE))) begin
        snap_rat[rob]  = rat_m;
        snap_pops[rob] = popped.size();
      end
      if (bus.mispredict) begin
        // tags handed out after the snapshot go back to the front of the list
        n = popped.size() - snap_pops[int'(bus.mispredict_rob_idx)];
        for (int k = 0; k < n; k++) free_q.push_front(popped.pop_back());
        rat_m = snap_rat[int'(bus.mispredict_rob_idx)];
      end
      if (bus.commit_valid && bus.commit_old_rd != '0) free_q.push_back(int'(bus.commit_old_rd));
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    bus.DC_in_valid = 0; bus.DC_in_pc = '0; bus.DC_in_inst = '0; bus.DC_in_imm = '0;
    bus.DC_in_op = '0; bus.DC_in_f3 = '0; bus.DC_in_f7 = '0; bus.DC_in_fu_sel = '0;
    bus.DC_in_jump = 0; bus.DC_in_rs1 = '0; bus.DC_in_rs2 = '0; bus.DC_in_rd = '0;
    bus.DC_in_rd_we = 0; bus.ROB_tail = '0; bus.ROB_ready = 1; bus.LQ_tail = '0;
    bus.SQ_tail = '0; bus.IS_ready = 1; bus.WB_valid = 0; bus.WB_rd = '0;
    bus.commit_valid = 0; bus.commit_old_rd = '0; bus.mispredict = 0;
    bus.mispredict_rob_idx = '0; bus.flush_mask = '0;
  endtask

  task automatic set_inst(input int rs1, input int rs2, input int rd, input int we,
                          input int op, input int jump, input int rob);
    bus.DC_in_valid  = 1;
    bus.DC_in_rs1    = 5'(rs1);
    bus.DC_in_rs2    = 5'(rs2);
    bus.DC_in_rd     = 5'(rd);
    bus.DC_in_rd_we  = (we != 0);
    bus.DC_in_op     = 5'(op);
    bus.DC_in_jump   = (jump != 0);
    bus.ROB_tail     = 3'(rob);
    bus.DC_in_pc     = $urandom();
    bus.DC_in_inst   = $urandom();
    bus.DC_in_imm    = $urandom();
    bus.DC_in_f3     = 3'($urandom_range(0, 7));
    bus.DC_in_f7     = 7'($urandom_range(0, 127));
    bus.DC_in_fu_sel = 3'($urandom_range(0, 7));
    bus.LQ_tail      = 2'($urandom_range(0, 3));
    bus.SQ_tail      = 2'($urandom_range(0, 3));
  endtask

  task automatic offer(input int rs1, input int rs2, input int rd, input int we,
                       input int op, input int jump, input int rob);
    set_inst(rs1, rs2, rd, we, op, jump, rob);
    cycle();
    bus.DC_in_valid  = 0;
    bus.WB_valid     = 0;
    bus.commit_valid = 0;
    bus.mispredict   = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    cycle();
    cycle();
    rst = 1;
  endtask

  initial begin
    model_reset();
    idle();
    #2;
    // reset state and first rename
    do_reset();
    cycle();
    offer(1, 2, 5, 1, int'(R_TYPE), 0, 0);
    check("add_prd",   32'(bus.IS_in_rd), 32);
    check("add_old",   32'(bus.IS_in_old_rd), 5);
    check("add_v1",    32'(bus.IS_in_rs1_valid), 1);
    check("add_valid", 32'(bus.DC_valid), 1);

    // RAW on a freshly renamed register, then same-cycle writeback bypass
    do_reset();
    offer(0, 0, 5, 1, int'(R_TYPE), 0, 0);
    offer(5, 0, 0, 0, int'(STORE), 0, 1);
    check("raw_prs1", 32'(bus.IS_in_rs1), 32);
    check("raw_v1",   32'(bus.IS_in_rs1_valid), 0);
    bus.WB_valid = 1; bus.WB_rd = 7'd32;
    offer(5, 0, 0, 0, int'(STORE), 0, 2);
    check("bypass_v1", 32'(bus.IS_in_rs1_valid), 1);

    // free list exhaustion and recycle of a committed tag
    do_reset();
    for (int i = 0; i < 96; i++) offer(0, 0, (i % 31) + 1, 1, int'(I_TYPE), 0, i % 8);
    set_inst(0, 0, 9, 1, int'(I_TYPE), 0, 0);
    cycle();
    check("empty_rd_ready", 32'(obs_ready), 0);
    bus.DC_in_valid = 0;
    offer(1, 2, 0, 0, int'(STORE), 0, 1);
    check("empty_store_ready", 32'(obs_ready), 1);
    bus.commit_valid = 1; bus.commit_old_rd = 7'd5;
    cycle();
    bus.commit_valid = 0;
    offer(0, 0, 9, 1, int'(I_TYPE), 0, 2);
    check("recycled_prd", 32'(bus.IS_in_rd), 5);

    // branch snapshot and recovery
    do_reset();
    offer(0, 0, 5, 1, int'(R_TYPE), 0, 1);
    offer(5, 0, 0, 0, int'(B_TYPE), 0, 2);
    offer(0, 0, 6, 1, int'(R_TYPE), 0, 3);
    check("x6_prd", 32'(bus.IS_in_rd), 33);
    set_inst(1, 1, 8, 1, int'(R_TYPE), 0, 4);
    bus.mispredict = 1; bus.mispredict_rob_idx = 3'd2; bus.flush_mask = 8'hF8;
    cycle();
    check("flush_ready", 32'(obs_ready), 0);
    check("flush_valid", 32'(bus.DC_valid), 0);
    bus.mispredict = 0; bus.flush_mask = '0; bus.DC_in_valid = 0;
    offer(6, 5, 7, 1, int'(R_TYPE), 0, 3);
    check("restored_x6", 32'(bus.IS_in_rs1), 6);
    check("kept_x5",     32'(bus.IS_in_rs2), 32);
    check("reuse_p33",   32'(bus.IS_in_rd), 33);

    // issue-queue backpressure
    do_reset();
    offer(0, 0, 5, 1, int'(R_TYPE), 0, 0);
    saved_pc = bus.IS_in_pc;
    bus.IS_ready = 0;
    set_inst(0, 0, 6, 1, int'(R_TYPE), 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_ready", 32'(obs_ready), 0);
      check("stall_pc",    bus.IS_in_pc, saved_pc);
      check("stall_prd",   32'(bus.IS_in_rd), 32);
    end
    bus.IS_ready = 1;
    cycle();
    bus.DC_in_valid = 0;
    check("after_stall_prd", 32'(bus.IS_in_rd), 33);

    // randomized traffic, no recovery
    do_reset();
    for (int c = 0; c < 500; c++) begin
      set_inst($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 1), $urandom_range(0, 8), ($urandom_range(0, 9) == 0) ? 1 : 0,
               $urandom_range(0, 7));
      bus.DC_in_valid = ($urandom_range(0, 99) < 75);
      bus.IS_ready    = ($urandom_range(0, 99) < 70);
      bus.ROB_ready   = ($urandom_range(0, 99) < 90);
      bus.WB_valid    = ($urandom_range(0, 1) == 1);
      bus.WB_rd       = 7'($urandom_range(0, 127));
      bus.commit_valid = 0;
      if (pend_old.size() != 0 && $urandom_range(0, 99) < 35) begin
        bus.commit_valid  = 1;
        bus.commit_old_rd = 7'(pend_old.pop_front());
      end
      cycle();
    end
    idle();

    // asynchronous reset in the middle of traffic
    bus.IS_ready = 0;
    offer(0, 0, 3, 1, int'(R_TYPE), 0, 6);
    rst = 0;
    #1;
    check("arst_valid", 32'(bus.DC_valid), 0);
    check("arst_prd",   32'(bus.IS_in_rd), 0);
    check("arst_pc",    bus.IS_in_pc, 0);
    check("arst_rob",   32'(bus.IS_in_rob_idx), 0);
    check("arst_ready", 32'(bus.DC_in_ready), 0);
    model_reset();
    idle();
    cycle();
    rst = 1;
    offer(3, 31, 4, 1, int'(R_TYPE), 0, 0);
    check("post_rst_prs1", 32'(bus.IS_in_rs1), 3);
    check("post_rst_prs2", 32'(bus.IS_in_rs2), 31);
    check("post_rst_prd",  32'(bus.IS_in_rd), 32);
    check("post_rst_old",  32'(bus.IS_in_old_rd), 4);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
